// File: rtl/riscv_pkg.sv
// Shared RV64I core definitions.
//   XLEN        : default datapath width
//   alu_op_e    : ALU operation select carried in the control bundle
//   ctrl_t      : decoded control bundle passed from ID to EX
//   CTRL_BUBBLE : all-zero control word; a bubble that writes nothing and
//                 touches no memory
package riscv_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_AUIPC= 4'd11
  } alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    alu_op_e    alu_op;
    logic [2:0] funct3;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (pure combinational).
// Flags when the instruction in ID reads a register that the load currently
// in EX will write; that value is not available until after MEM.
//   id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2 : ID source info
//   ex_valid, ex_mem_read, ex_rd                        : EX producer info
//   hz                                                  : hazard flag
module load_use_detect (
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hz
);

  logic rs1_hit, rs2_hit;

  // Only count a source when the instruction really reads it: a stale rs
  // field (e.g. in lui) must not cause a spurious stall.
  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

  // x0 is never a true dependency.
  assign hz = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0)
              && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// external stall.
//   clk, rst_n         : clock, async active-low reset
//   id_*               : decoded instruction from ID
//   flush_ex           : taken branch/jump in EX; squash the ID instruction
//   stall_ext          : memory stall; freeze this register and counters
//   ex_*               : registered instruction presented to EX
//   stall_if_id        : combinational freeze of PC and IF/ID
//   load_use_cnt       : saturating count of load-use bubbles
//   flush_cnt          : saturating count of flush bubbles
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  ctrl_t            id_ctrl,
  input  logic             flush_ex,
  input  logic             stall_ext,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output ctrl_t            ex_ctrl,
  output logic             stall_if_id,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic hz;
  logic take_bubble;  // flush, hazard or empty ID slot
  logic load_bubble;  // any non-stalled edge that inserts a bubble

  load_use_detect u_lud (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (ex_rd),
    .hz          (hz)
  );

  // A flushed ID instruction is wrong-path and gets dropped, so a hazard
  // against it must not freeze fetch.
  assign stall_if_id = stall_ext || (hz && !flush_ex);

  assign take_bubble = flush_ex || hz || !id_valid;
  assign load_bubble = !stall_ext && take_bubble;

  // Pipeline payload. Bubbles zero the indices and control so the
  // forwarding unit can never match one; data is zeroed for determinism.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ctrl     <= CTRL_BUBBLE;
    end else if (load_bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ctrl     <= CTRL_BUBBLE;
    end else if (!stall_ext) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_ctrl     <= id_ctrl;
    end
  end

  // Bubble counters: flush wins over hazard, neither counts while stalled,
  // and an idle ID slot counts as neither.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_use_cnt <= '0;
      flush_cnt    <= '0;
    end else if (!stall_ext) begin
      if (flush_ex) begin
        if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
      end else if (hz) begin
        if (load_use_cnt != CNT_MAX) load_use_cnt <= load_use_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage (CNT_W=4 so saturation is reachable).
module tb_id_ex_stage;
  import riscv_pkg::*;

  localparam int XL = 64;
  localparam int CW = 4;

  logic          clk, rst_n;
  logic          id_valid, id_uses_rs1, id_uses_rs2, flush_ex, stall_ext;
  logic [XL-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  ctrl_t         id_ctrl;
  logic          ex_valid, stall_if_id;
  logic [XL-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  ctrl_t         ex_ctrl;
  logic [CW-1:0] load_use_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  id_ex_stage #(.XLEN(XL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush_ex(flush_ex), .stall_ext(stall_ext),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .stall_if_id(stall_if_id),
    .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // after that settle point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic mrd, input logic [63:0] pc);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    id_pc       = pc;
    id_rs1_data = pc + 64'h1000;
    id_rs2_data = pc + 64'h2000;
    id_imm      = pc + 64'h3000;
    id_ctrl            = CTRL_BUBBLE;
    id_ctrl.reg_write  = 1'b1;
    id_ctrl.mem_read   = mrd;
    id_ctrl.mem_to_reg = mrd;
    id_ctrl.alu_src    = mrd;
    id_ctrl.alu_op     = ALU_ADD;
    id_ctrl.funct3     = mrd ? 3'b011 : 3'b000;
  endtask

  // One load x5 followed by a dependent add: exactly one load-use bubble.
  task automatic one_hazard();
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 64'h200);
    step();
    set_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 64'h204);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    flush_ex = 1'b0;
    stall_ext = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0);
    #3;
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_rd", 64'(ex_rd), 64'd0);
    chk("rst_ctrl", 64'(ex_ctrl), 64'd0);
    chk("rst_lu_cnt", 64'(load_use_cnt), 64'd0);
    chk("rst_fl_cnt", 64'(flush_cnt), 64'd0);
    chk("rst_stall", 64'(stall_if_id), 64'd0);
    #9 rst_n = 1'b1;   // released at t=12, clear of the t=15 edge
    step();            // t=16

    // Load x5 enters EX.
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 64'h100);
    step();
    chk("ld_valid", 64'(ex_valid), 64'd1);
    chk("ld_rd", 64'(ex_rd), 64'd5);
    chk("ld_mem_read", 64'(ex_ctrl.mem_read), 64'd1);
    chk("ld_pc", ex_pc, 64'h100);

    // add x6,x5,x7 -> hazard
    set_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 64'h104);
    #1;
    chk("hz_stall", 64'(stall_if_id), 64'd1);
    step();
    chk("hz_bub_valid", 64'(ex_valid), 64'd0);
    chk("hz_bub_rd", 64'(ex_rd), 64'd0);
    chk("hz_bub_rs1", 64'(ex_rs1), 64'd0);
    chk("hz_bub_ctrl", 64'(ex_ctrl), 64'd0);
    chk("hz_bub_pc", ex_pc, 64'd0);
    chk("hz_lu_cnt", 64'(load_use_cnt), 64'd1);
    chk("hz_release", 64'(stall_if_id), 64'd0);
    step();
    chk("add_valid", 64'(ex_valid), 64'd1);
    chk("add_rs1", 64'(ex_rs1), 64'd5);
    chk("add_rs2", 64'(ex_rs2), 64'd7);
    chk("add_rd", 64'(ex_rd), 64'd6);
    chk("add_pc", ex_pc, 64'h104);
    chk("add_rs1_data", ex_rs1_data, 64'h1104);
    chk("add_rs2_data", ex_rs2_data, 64'h2104);
    chk("add_imm", ex_imm, 64'h3104);
    chk("add_reg_write", 64'(ex_ctrl.reg_write), 64'd1);

    // Load x5 then lui-style instruction with stale rs1=5 field: no hazard.
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 64'h110);
    step();
    set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 64'h114);
    #1;
    chk("nouse_stall", 64'(stall_if_id), 64'd0);
    step();
    chk("nouse_valid", 64'(ex_valid), 64'd1);
    chk("nouse_pc", ex_pc, 64'h114);
    chk("nouse_lu_cnt", 64'(load_use_cnt), 64'd1);

    // Load to x0, consumer reads x0: no hazard.
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 64'h120);
    step();
    set_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 64'h124);
    #1;
    chk("x0_stall", 64'(stall_if_id), 64'd0);
    step();
    chk("x0_valid", 64'(ex_valid), 64'd1);
    chk("x0_rd", 64'(ex_rd), 64'd8);
    chk("x0_lu_cnt", 64'(load_use_cnt), 64'd1);

    // Hazard and flush together: flush wins, no freeze, flush counted only.
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 64'h130);
    step();
    set_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 64'h134);
    flush_ex = 1'b1;
    #1;
    chk("hzfl_stall", 64'(stall_if_id), 64'd0);
    step();
    flush_ex = 1'b0;
    chk("hzfl_valid", 64'(ex_valid), 64'd0);
    chk("hzfl_rd", 64'(ex_rd), 64'd0);
    chk("hzfl_fl_cnt", 64'(flush_cnt), 64'd1);
    chk("hzfl_lu_cnt", 64'(load_use_cnt), 64'd1);

    // Valid non-load x9 in EX, then 3 cycles of stall_ext with flush pending.
    set_id(1'b1, 5'd2, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 64'h140);
    step();
    set_id(1'b1, 5'd4, 5'd4, 5'd10, 1'b1, 1'b1, 1'b0, 64'h144);
    stall_ext = 1'b1;
    flush_ex  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stl_stall", 64'(stall_if_id), 64'd1);
      step();
      chk("stl_rd", 64'(ex_rd), 64'd9);
      chk("stl_pc", ex_pc, 64'h140);
      chk("stl_valid", 64'(ex_valid), 64'd1);
      chk("stl_fl_cnt", 64'(flush_cnt), 64'd1);
    end
    stall_ext = 1'b0;
    step();
    flush_ex = 1'b0;
    chk("stlrel_valid", 64'(ex_valid), 64'd0);
    chk("stlrel_rd", 64'(ex_rd), 64'd0);
    chk("stlrel_fl_cnt", 64'(flush_cnt), 64'd2);
    step();
    chk("stlrel_fl_once", 64'(flush_cnt), 64'd2);
    chk("next_pc", ex_pc, 64'h144);

    // Empty ID slot: ordinary bubble, not counted.
    set_id(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 64'h150);
    step();
    chk("idle_valid", 64'(ex_valid), 64'd0);
    chk("idle_rd", 64'(ex_rd), 64'd0);
    chk("idle_ctrl", 64'(ex_ctrl), 64'd0);
    chk("idle_lu_cnt", 64'(load_use_cnt), 64'd1);
    chk("idle_fl_cnt", 64'(flush_cnt), 64'd2);

    // Drive load_use_cnt to 15, then one more hazard must not wrap.
    for (int i = 0; i < 14; i++) one_hazard();
    chk("sat_reach", 64'(load_use_cnt), 64'd15);
    one_hazard();
    chk("sat_hold", 64'(load_use_cnt), 64'd15);

    // Reset asserted in the middle of a stall.
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 64'h160);
    step();
    stall_ext = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(ex_valid), 64'd0);
    chk("mrst_rd", 64'(ex_rd), 64'd0);
    chk("mrst_pc", ex_pc, 64'd0);
    chk("mrst_ctrl", 64'(ex_ctrl), 64'd0);
    chk("mrst_lu_cnt", 64'(load_use_cnt), 64'd0);
    chk("mrst_fl_cnt", 64'(flush_cnt), 64'd0);
    chk("mrst_stall_ext", 64'(stall_if_id), 64'd1);
    stall_ext = 1'b0;
    #1;
    chk("mrst_stall_clr", 64'(stall_if_id), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
